fir_coef_loader: RTL and testbench

Streams a new coefficient set into the FIR datapath over a valid/ready beat interface.
- Beats are collected in a shadow bank.
- The full set commits atomically to the active bank, which drives the filter's tap inputs.
- Supports symmetric (half-set, mirrored) loads, abort, and framing-error detection.
- Sits between the control/host side and the pipelined FIR MAC array, replacing hard-coded taps.

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_coef_loader_if.sv | 14 +
 rtl/fir_coef_loader_bank.sv | 36 +++
 rtl/fir_coef_loader.sv | 98 +++++++++
 tb/tb_fir_coef_loader.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, loader state encoding and tap mirror helper for the FIR coefficient loader.
package fir_pkg;

    localparam int TAP_WIDTH_DEF = 32;
    localparam int TAP_COUNT_DEF = 102;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERR} state_e;

    function automatic int mirror_idx(input int count, input int idx);
        return count - 1 - idx;
    endfunction

endpackage

// File: rtl/fir_coef_loader_if.sv
// fir_coef_loader_if: host-side load control plus the valid/ready coefficient beat channel.
interface fir_coef_loader_if #(
    parameter int TAP_WIDTH = fir_pkg::TAP_WIDTH_DEF
);
    logic                 load_start;
    logic                 load_abort;
    logic                 coef_valid;
    logic                 coef_ready;
    logic                 coef_last;
    logic [TAP_WIDTH-1:0] coef_data;

    modport master (output load_start, load_abort, coef_valid, coef_data, coef_last, input coef_ready);
    modport slave  (input load_start, load_abort, coef_valid, coef_data, coef_last, output coef_ready);
endinterface

// File: rtl/fir_coef_loader_bank.sv
// fir_coef_bank: shadow bank written beat by beat (optionally mirrored) and an active bank
// that takes the whole shadow set in one edge on commit.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAP_WIDTH = TAP_WIDTH_DEF,
    parameter int TAP_COUNT = TAP_COUNT_DEF,
    parameter bit SYMMETRIC = 1'b1,
    parameter int IW        = 6
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_en_i,
    input  logic [IW-1:0]                  wr_idx_i,
    input  logic [TAP_WIDTH-1:0]           wr_data_i,
    input  logic                           commit_i,
    output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_flat_o
);
    logic [TAP_COUNT*TAP_WIDTH-1:0] shadow_q, active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            for (int k = 0; k < TAP_COUNT; k++)
                if (wr_en_i && (k == int'(wr_idx_i) ||
                    (SYMMETRIC && k == mirror_idx(TAP_COUNT, int'(wr_idx_i)))))
                    shadow_q[k*TAP_WIDTH +: TAP_WIDTH] <= wr_data_i;
            if (commit_i)
                active_q <= shadow_q;
        end
    end

    assign taps_flat_o = active_q;
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams a coefficient set into a shadow bank and commits it atomically
// to the FIR tap inputs, with abort and framing-error detection.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int TAP_WIDTH = TAP_WIDTH_DEF,
    parameter int TAP_COUNT = TAP_COUNT_DEF,
    parameter bit SYMMETRIC = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    fir_coef_loader_if.slave               bus,
    output logic [TAP_COUNT*TAP_WIDTH-1:0] taps_flat_o,
    output logic                           taps_update_o,
    output logic                           busy_o,
    output logic                           load_error_o
);
    localparam int N_LOAD = SYMMETRIC ? TAP_COUNT / 2 : TAP_COUNT;
    localparam int IW = N_LOAD > 1 ? $clog2(N_LOAD) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_LOAD - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ready_q, ready_d, busy_q, busy_d, err_q, err_d, upd_q, upd_d;
    logic          fire;

    // Abort wins over a same-cycle beat, so the beat never reaches the shadow bank.
    assign fire = state_q == LOAD && bus.coef_valid && ready_q && !bus.load_abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, ERR: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (bus.load_abort)
                    state_d = IDLE;
                else if (fire) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == LAST_IDX && bus.coef_last) ? COMMIT :
                              (idx_q == LAST_IDX || bus.coef_last) ? ERR : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they track state_q exactly.
    always_comb begin
        ready_d = state_d == LOAD;
        busy_d  = state_d == LOAD || state_d == COMMIT;
        err_d   = state_d == ERR;
        upd_d   = state_q == COMMIT;
    end

    fir_coef_bank #(
        .TAP_WIDTH (TAP_WIDTH),
        .TAP_COUNT (TAP_COUNT),
        .SYMMETRIC (SYMMETRIC),
        .IW        (IW)
    ) u_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en_i     (fire),
        .wr_idx_i    (idx_q),
        .wr_data_i   (bus.coef_data),
        .commit_i    (state_q == COMMIT),
        .taps_flat_o (taps_flat_o)
    );

    assign bus.coef_ready = ready_q;
    assign taps_update_o  = upd_q;
    assign busy_o         = busy_q;
    assign load_error_o   = err_q;
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: scoreboarded bench for symmetric and full-set coefficient loads.
module tb_fir_coef_loader;
    localparam int TW = 32;
    localparam int TC = 102;
    localparam int W  = TW * TC;

    logic clk, reset_n;
    logic start_r, abort_r, valid_r, last_r, sel_r;
    logic [TW-1:0] data_r;
    logic [TW-1:0] bv [TC];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] cur_exp;
    logic [W-1:0] s_taps, a_taps, taps_w;
    logic s_upd, a_upd, s_busy, a_busy, s_err, a_err;
    logic ready_w, upd_w, busy_w, err_w;
    int n_checks, n_fail;

    fir_coef_loader_if #(.TAP_WIDTH(TW)) s_if ();
    fir_coef_loader_if #(.TAP_WIDTH(TW)) a_if ();

    assign s_if.load_start = start_r && !sel_r;
    assign s_if.load_abort = abort_r && !sel_r;
    assign s_if.coef_valid = valid_r && !sel_r;
    assign s_if.coef_last  = last_r;
    assign s_if.coef_data  = data_r;
    assign a_if.load_start = start_r && sel_r;
    assign a_if.load_abort = abort_r && sel_r;
    assign a_if.coef_valid = valid_r && sel_r;
    assign a_if.coef_last  = last_r;
    assign a_if.coef_data  = data_r;

    assign ready_w = sel_r ? a_if.coef_ready : s_if.coef_ready;
    assign taps_w  = sel_r ? a_taps : s_taps;
    assign upd_w   = sel_r ? a_upd : s_upd;
    assign busy_w  = sel_r ? a_busy : s_busy;
    assign err_w   = sel_r ? a_err : s_err;

    fir_coef_loader #(.TAP_WIDTH(TW), .TAP_COUNT(TC), .SYMMETRIC(1'b1)) dut_s (
        .clk (clk), .reset_n (reset_n), .bus (s_if.slave),
        .taps_flat_o (s_taps), .taps_update_o (s_upd), .busy_o (s_busy), .load_error_o (s_err)
    );

    fir_coef_loader #(.TAP_WIDTH(TW), .TAP_COUNT(TC), .SYMMETRIC(1'b0)) dut_a (
        .clk (clk), .reset_n (reset_n), .bus (a_if.slave),
        .taps_flat_o (a_taps), .taps_update_o (a_upd), .busy_o (a_busy), .load_error_o (a_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] build_exp(input int n, input bit sym);
        logic [W-1:0] f;
        f = '0;
        for (int k = 0; k < n; k++) begin
            f[k*TW +: TW] = bv[k];
            if (sym) f[(TC-1-k)*TW +: TW] = bv[k];
        end
        return f;
    endfunction

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < TC; k++)
            if (a[k*TW +: TW] !== b[k*TW +: TW]) return k;
        return 0;
    endfunction

    function automatic logic [TW-1:0] tap(input int k);
        return taps_w[k*TW +: TW];
    endfunction

    task automatic do_load(input int n, input int last_at, input bit gaps, input int abort_at);
        int i, cyc;
        logic acc;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        i = 0;
        cyc = 0;
        while (i < n) begin
            valid_r = gaps ? cyc[0] : 1'b1;
            data_r  = bv[i];
            last_r  = (i + 1 == last_at);
            abort_r = (i + 1 == abort_at);
            acc     = valid_r && ready_w;
            @(posedge clk); #1;
            cyc++;
            if (abort_r) i = n;
            else if (acc) i++;
            if (cyc > 4 * n + 20) begin
                n_checks++; n_fail++;
                $display("FAIL load_timeout: accepted %0d beats, required %0d", i, n);
                i = n;
            end
        end
        valid_r = 1'b0;
        last_r  = 1'b0;
        abort_r = 1'b0;
    endtask

    task automatic await_commit(input string name);
        logic [W-1:0] e;
        n_checks++;
        if (upd_w !== 1'b0 || busy_w !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_commit_cycle: upd=%b busy=%b, required upd=0 busy=1", name, upd_w, busy_w);
        end
        @(posedge clk); #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: queue empty, required one expected set", name);
            e = cur_exp;
        end else begin
            e = exp_q.pop_front();
        end
        if (upd_w !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_update: got %b, required 1", name, upd_w);
        end
        n_checks++;
        if (taps_w !== e) begin
            n_fail++;
            $display("FAIL %s_taps: tap %0d got %0h, required %0h", name, first_diff(taps_w, e),
                     taps_w[first_diff(taps_w, e)*TW +: TW], e[first_diff(taps_w, e)*TW +: TW]);
        end
        cur_exp = e;
        @(posedge clk); #1;
        n_checks++;
        if (upd_w !== 1'b0 || busy_w !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after: upd=%b busy=%b, required 0 0", name, upd_w, busy_w);
        end
    endtask

    task automatic quiet_hold(input string name);
        logic seen;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (upd_w !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL %s_no_update: got pulse, required none", name);
        end
        n_checks++;
        if (taps_w !== cur_exp) begin
            n_fail++;
            $display("FAIL %s_taps_hold: tap %0d got %0h, required %0h", name, first_diff(taps_w, cur_exp),
                     taps_w[first_diff(taps_w, cur_exp)*TW +: TW], cur_exp[first_diff(taps_w, cur_exp)*TW +: TW]);
        end
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            sel_r = s[0];
            #1;
            n_checks++;
            if (taps_w !== '0 || ready_w !== 1'b0 || upd_w !== 1'b0 || busy_w !== 1'b0 || err_w !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: taps_zero=%b rdy=%b upd=%b busy=%b err=%b, required 1 0 0 0 0",
                         s, taps_w == '0, ready_w, upd_w, busy_w, err_w);
            end
        end
        sel_r = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready_w !== 1'b0 || busy_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: rdy=%b busy=%b, required 0 0", ready_w, busy_w);
        end
        cur_exp = '0;
    endtask

    task automatic test_sym_load;
        for (int k = 0; k < 51; k++) bv[k] = TW'(k + 1);
        exp_q.push_back(build_exp(51, 1'b1));
        do_load(51, 51, 1'b0, 0);
        await_commit("sym");
        n_checks++;
        if (tap(0) !== 32'd1 || tap(101) !== 32'd1 || tap(50) !== 32'd51 || tap(51) !== 32'd51) begin
            n_fail++;
            $display("FAIL sym_spot: t0=%0d t101=%0d t50=%0d t51=%0d, required 1 1 51 51",
                     tap(0), tap(101), tap(50), tap(51));
        end
    endtask

    task automatic test_back_pressure;
        for (int k = 0; k < 51; k++) bv[k] = 32'hFFFF_FFF0;
        exp_q.push_back(build_exp(51, 1'b1));
        do_load(51, 51, 1'b1, 0);
        n_checks++;
        if (err_w !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_error: got %b, required 0", err_w);
        end
        await_commit("gaps");
        n_checks++;
        if (tap(77) !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL gaps_tap77: got %0h, required fffffff0", tap(77));
        end
    endtask

    task automatic test_early_last;
        for (int k = 0; k < 51; k++) bv[k] = 32'h1000 + TW'(k);
        do_load(10, 10, 1'b0, 0);
        n_checks++;
        if (err_w !== 1'b1 || ready_w !== 1'b0 || busy_w !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err: err=%b rdy=%b busy=%b, required 1 0 0", err_w, ready_w, busy_w);
        end
        quiet_hold("early");
        for (int k = 0; k < 51; k++) bv[k] = 32'd200 + TW'(k);
        exp_q.push_back(build_exp(51, 1'b1));
        do_load(51, 51, 1'b0, 0);
        n_checks++;
        if (err_w !== 1'b0) begin
            n_fail++;
            $display("FAIL early_clear: err got %b, required 0", err_w);
        end
        await_commit("recover");
    endtask

    task automatic test_missing_last;
        for (int k = 0; k < 51; k++) bv[k] = 32'h5000 + TW'(k);
        do_load(51, 0, 1'b0, 0);
        n_checks++;
        if (err_w !== 1'b1 || ready_w !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_err: err=%b rdy=%b, required 1 0", err_w, ready_w);
        end
        quiet_hold("missing");
    endtask

    task automatic test_abort;
        for (int k = 0; k < 51; k++) bv[k] = 32'h8000_0000 | TW'(k);
        do_load(20, 0, 1'b0, 20);
        n_checks++;
        if (err_w !== 1'b0 || busy_w !== 1'b0 || ready_w !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: err=%b busy=%b rdy=%b, required 0 0 0", err_w, busy_w, ready_w);
        end
        quiet_hold("abort");
        for (int k = 0; k < 51; k++) bv[k] = 32'h7FFF_FFFF;
        exp_q.push_back(build_exp(51, 1'b1));
        do_load(51, 51, 1'b0, 0);
        await_commit("max");
    endtask

    task automatic test_reset_mid_load;
        for (int k = 0; k < 51; k++) bv[k] = 32'h0000_0A00 + TW'(k);
        do_load(29, 0, 1'b0, 0);
        n_checks++;
        if (busy_w !== 1'b1 || ready_w !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_busy: busy=%b rdy=%b, required 1 1", busy_w, ready_w);
        end
        valid_r = 1'b1;
        data_r  = bv[29];
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (taps_w !== '0 || ready_w !== 1'b0 || upd_w !== 1'b0 || busy_w !== 1'b0 || err_w !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reset: taps_zero=%b rdy=%b upd=%b busy=%b err=%b, required 1 0 0 0 0",
                     taps_w == '0, ready_w, upd_w, busy_w, err_w);
        end
        valid_r = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cur_exp = '0;
    endtask

    task automatic test_full_load;
        sel_r = 1'b1;
        #1;
        for (int k = 0; k < TC; k++) bv[k] = TW'(k - 50);
        exp_q.push_back(build_exp(TC, 1'b0));
        do_load(TC, TC, 1'b0, 0);
        await_commit("full");
        n_checks++;
        if (tap(0) !== 32'hFFFF_FFCE || tap(50) !== 32'd0 || tap(101) !== 32'd51) begin
            n_fail++;
            $display("FAIL full_spot: t0=%0h t50=%0h t101=%0h, required ffffffce 0 33",
                     tap(0), tap(50), tap(101));
        end
        sel_r = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start_r  = 1'b0;
        abort_r  = 1'b0;
        valid_r  = 1'b0;
        last_r   = 1'b0;
        sel_r    = 1'b0;
        data_r   = '0;
        #12;
        test_reset;
        test_sym_load;
        test_back_pressure;
        test_early_last;
        test_missing_last;
        test_abort;
        test_reset_mid_load;
        test_full_load;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
